// File: rtl/dds_nco_pipe.sv
// Numerically controlled oscillator for the DDS path: phase accumulator with coherent FTW
// update, square/saw/triangle shaping and amplitude scaling over a 3-register pipeline.
module dds_nco_pipe #(
  parameter int ACC_W = 16,
  parameter int OUT_W = 8,
  parameter int AMP_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             enable_in,
  input  logic             phase_clr_in,
  input  logic [ACC_W-1:0] ftw_in,
  input  logic             ftw_valid_in,
  output logic             ftw_ready_out,
  input  logic [1:0]       wavesel_in,
  input  logic [AMP_W-1:0] amp_in,
  output logic [OUT_W-1:0] wave_out,
  output logic             wave_valid_out,
  output logic             wrap_out
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_PEND = 1'b1;
  localparam int   STAGES  = 2;
  localparam int   PW      = OUT_W + AMP_W + 1;

  logic [ACC_W-1:0] acc, ftw_active, ftw_pending;
  logic [ACC_W:0]   acc_sum;
  logic             carry;
  logic             state, state_nxt, ready_q;
  logic             ftw_take, ftw_apply;
  logic [STAGES:0]  vld_pipe;  // [0] acc stage, [1] shaping stage, [2] output stage

  assign acc_sum = {1'b0, acc} + {1'b0, ftw_active};
  assign carry   = acc_sum[ACC_W];

  // A new FTW only lands on a wrap, a clear or while paused, so the phase never jumps mid-cycle.
  assign ftw_take  = (state == ST_IDLE) && ftw_valid_in && ready_q;
  assign ftw_apply = (state == ST_PEND) && ((enable_in && carry) || phase_clr_in || !enable_in);

  always_comb begin
    state_nxt = state;
    if (ftw_take)       state_nxt = ST_PEND;
    else if (ftw_apply) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b0;
      ftw_pending <= '0;
      ftw_active  <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == ST_IDLE);
      if (ftw_take)  ftw_pending <= ftw_in;
      if (ftw_apply) ftw_active  <= ftw_pending;
    end
  end

  assign ftw_ready_out = ready_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      acc      <= '0;
      wrap_out <= 1'b0;
      vld_pipe <= '0;
    end else begin
      if (phase_clr_in) begin
        acc      <= '0;
        wrap_out <= 1'b0;
      end else if (enable_in) begin
        acc      <= acc_sum[ACC_W-1:0];
        wrap_out <= carry;
      end else begin
        wrap_out <= 1'b0;
      end
      vld_pipe <= {vld_pipe[STAGES-1:0], enable_in};
    end
  end

  // Shaping works on the top OUT_W phase bits; subtracting h from an unsigned ramp is an MSB flip.
  logic [OUT_W-1:0] p, raw_d, raw_q;
  logic [OUT_W-2:0] tri_t;

  assign p     = acc[ACC_W-1 -: OUT_W];
  assign tri_t = p[OUT_W-1] ? ~p[OUT_W-2:0] : p[OUT_W-2:0];

  always_comb begin
    raw_d = '0;
    case (wavesel_in)
      2'b01:   raw_d = p[OUT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      2'b10:   raw_d = {~p[OUT_W-1], p[OUT_W-2:0]};
      2'b11:   raw_d = {~tri_t[OUT_W-2], tri_t[OUT_W-3:0], 1'b0};
      default: raw_d = '0;
    endcase
  end

  // Gain is below unity, so the floored product always fits back in OUT_W bits.
  logic signed [PW-1:0] prod;
  logic                 prod_unused;

  assign prod        = $signed({{(AMP_W+1){raw_q[OUT_W-1]}}, raw_q}) * $signed({{OUT_W{1'b0}}, 1'b0, amp_in});
  assign prod_unused = ^{prod[AMP_W-1:0], prod[PW-1]};

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      raw_q    <= '0;
      wave_out <= '0;
    end else begin
      raw_q    <= raw_d;
      wave_out <= prod[AMP_W +: OUT_W];
    end
  end

  assign wave_valid_out = vld_pipe[STAGES];

endmodule

// File: tb/tb_dds_nco_pipe.sv
// Directed bench for dds_nco_pipe at ACC_W=16, OUT_W=8, AMP_W=8.
module tb_dds_nco_pipe;

  logic        clk_in = 1'b0;
  logic        rst_n, enable_in, phase_clr_in, ftw_valid_in, ftw_ready_out;
  logic [15:0] ftw_in;
  logic [1:0]  wavesel_in;
  logic [7:0]  amp_in;
  logic [7:0]  wave_out;
  logic        wave_valid_out, wrap_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  dds_nco_pipe #(.ACC_W(16), .OUT_W(8), .AMP_W(8)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .enable_in(enable_in), .phase_clr_in(phase_clr_in),
    .ftw_in(ftw_in), .ftw_valid_in(ftw_valid_in), .ftw_ready_out(ftw_ready_out),
    .wavesel_in(wavesel_in), .amp_in(amp_in), .wave_out(wave_out),
    .wave_valid_out(wave_valid_out), .wrap_out(wrap_out)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_wrap(input int budget, input string tag);
    int n = 0;
    while (wrap_out !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, int'(wrap_out), 1);
  endtask

  int wv, raw, kk;

  initial begin
    // 1: reset while valid and enable are driven high
    rst_n = 1'b0; enable_in = 1'b1; phase_clr_in = 1'b0;
    ftw_in = 16'h1234; ftw_valid_in = 1'b1; wavesel_in = 2'b10; amp_in = 8'd128;
    repeat (3) tick();
    chk("rst_wave", int'(wave_out), 0);
    chk("rst_valid", int'(wave_valid_out), 0);
    chk("rst_wrap", int'(wrap_out), 0);
    chk("rst_ready", int'(ftw_ready_out), 0);
    chk("rst_acc", int'(dut.acc), 0);
    rst_n = 1'b1; ftw_valid_in = 1'b0; enable_in = 1'b0;
    tick();
    chk("rel_ready", int'(ftw_ready_out), 1);
    chk("rel_acc", int'(dut.acc), 0);

    // 2: sawtooth, ftw 0x1000, amp 128 (applied immediately because paused)
    ftw_in = 16'h1000; ftw_valid_in = 1'b1;
    tick();
    chk("saw_acc_ready", int'(ftw_ready_out), 0);
    ftw_valid_in = 1'b0;
    tick();
    chk("saw_apply_ready", int'(ftw_ready_out), 1);
    enable_in = 1'b1;
    wait_wrap(40, "saw_first_wrap");
    tick(); tick();
    for (int k = 0; k < 16; k++) begin
      wv = int'($signed(wave_out));
      chk($sformatf("saw_wave%0d", k), wv, -64 + 8 * k);
      chk($sformatf("saw_wrap%0d", k), int'(wrap_out), (k == 14) ? 1 : 0);
      chk($sformatf("saw_valid%0d", k), int'(wave_valid_out), 1);
      tick();
    end

    // 3: coherent update offered at acc=0x3000; second offer while pending is dropped
    tick();
    chk("coh_acc3000", int'(dut.acc), 16'h3000);
    ftw_in = 16'h2000; ftw_valid_in = 1'b1;
    tick();
    chk("coh_ready_pend", int'(ftw_ready_out), 0);
    chk("coh_acc4000", int'(dut.acc), 16'h4000);
    ftw_in = 16'h0100;
    tick();
    chk("coh_ready_drop", int'(ftw_ready_out), 0);
    ftw_valid_in = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i < 11) begin
        chk($sformatf("coh_step%0d", i), int'(dut.acc), 16'h5000 + 16'h1000 * i);
        chk($sformatf("coh_ready%0d", i), int'(ftw_ready_out), 0);
        chk($sformatf("coh_nowrap%0d", i), int'(wrap_out), 0);
      end else begin
        chk("coh_wrap", int'(wrap_out), 1);
        chk("coh_acc0", int'(dut.acc), 0);
        chk("coh_ready_back", int'(ftw_ready_out), 1);
      end
    end
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk($sformatf("coh_new_acc%0d", j), int'(dut.acc), (16'h2000 * j) & 16'hFFFF);
      chk($sformatf("coh_new_wrap%0d", j), int'(wrap_out), (j == 8) ? 1 : 0);
    end

    // 4: triangle, ftw 0x0800 applied by a phase clear, amp 255
    ftw_in = 16'h0800; ftw_valid_in = 1'b1;
    tick();
    ftw_valid_in = 1'b0; phase_clr_in = 1'b1;
    tick();
    chk("tri_clr_acc", int'(dut.acc), 0);
    phase_clr_in = 1'b0; wavesel_in = 2'b11; amp_in = 8'd255;
    tick(); tick();
    for (int k = 0; k < 33; k++) begin
      kk = k % 32;
      raw = (kk < 16) ? (16 * kk - 128) : (126 - 16 * (kk - 16));
      // floor(raw*255/256) for |raw| <= 128 is raw-1 when positive, raw otherwise
      chk($sformatf("tri_wave%0d", k), int'($signed(wave_out)), (raw > 0) ? raw - 1 : raw);
      tick();
    end

    // 5: square, ftw 0x1000, clear on the carry edge
    ftw_in = 16'h1000; ftw_valid_in = 1'b1; wavesel_in = 2'b01;
    tick();
    ftw_valid_in = 1'b0; phase_clr_in = 1'b1;
    tick();
    phase_clr_in = 1'b0;
    repeat (15) tick();
    chk("sq_accF000", int'(dut.acc), 16'hF000);
    phase_clr_in = 1'b1;
    tick();
    chk("sq_clr_acc", int'(dut.acc), 0);
    chk("sq_clr_wrap", int'(wrap_out), 0);
    phase_clr_in = 1'b0;
    tick(); tick();
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("sq_wave%0d", k), int'($signed(wave_out)), (k < 8) ? 126 : -128);
      tick();
    end

    // 6: pause at acc=0x5000 for 5 cycles, then resume
    repeat (3) tick();
    chk("pz_acc5000", int'(dut.acc), 16'h5000);
    enable_in = 1'b0;
    tick();
    chk("pz_valid1", int'(wave_valid_out), 1);
    tick();
    chk("pz_valid2", int'(wave_valid_out), 1);
    tick();
    chk("pz_valid3", int'(wave_valid_out), 0);
    tick(); tick();
    chk("pz_hold", int'(dut.acc), 16'h5000);
    enable_in = 1'b1;
    tick();
    chk("pz_resume_acc", int'(dut.acc), 16'h6000);
    tick();
    chk("pz_rise2", int'(wave_valid_out), 0);
    tick();
    chk("pz_rise3", int'(wave_valid_out), 1);
    tick();
    chk("pz_wave_6000_7000", int'($signed(wave_out)), 126);
    tick();
    chk("pz_wave_8000", int'($signed(wave_out)), -128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
